// File: rtl/pipe_arith_pkg.sv
// Shared arithmetic-pipeline types: default operand width, half-width derivation
// and the per-stage valid/enable record used by the pipeline control.
package pipe_arith_pkg;

   localparam int DATA_W_DEF = 16;

   function automatic int halfWidth(input int w);
      return w / 2;
   endfunction

   typedef struct packed {
      logic v1;
      logic v2;
      logic v3;
      logic en1;
      logic en2;
      logic en3;
   } stageCtl_t;

endpackage

// File: rtl/pipelined_subtractor_16bit_if.sv
// Operand/result valid-ready bundle for the pipelined subtractor; the ovf
// result bit exists only when SUB_OVERFLOW_EN is defined.
interface pipelined_subtractor_16bit_if
   import pipe_arith_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              bIn;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] diff;
   logic              bOut;
   logic              busy;

`ifdef SUB_OVERFLOW_EN
   logic              ovf;

   modport master (
      output in_valid, a, b, bIn, out_ready,
      input  in_ready, out_valid, diff, bOut, busy, ovf
   );

   modport slave (
      input  in_valid, a, b, bIn, out_ready,
      output in_ready, out_valid, diff, bOut, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, bIn, out_ready,
      input  in_ready, out_valid, diff, bOut, busy
   );

   modport slave (
      input  in_valid, a, b, bIn, out_ready,
      output in_ready, out_valid, diff, bOut, busy
   );
`endif

endinterface

// File: rtl/ripple_borrow_sub.sv
// Combinational W-bit ripple-borrow subtractor: d = x - y - bIn, bOut = borrow out.
// No state, no latency, no handshake.
module ripple_borrow_sub #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bIn,
   output logic [W-1:0] d,
   output logic         bOut
);

   logic [W:0] br;

   always_comb begin
      br    = '0;
      d     = '0;
      br[0] = bIn;
      for (int i = 0; i < W; i++) begin
         d[i]    = x[i] ^ y[i] ^ br[i];
         br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
      end
   end

   assign bOut = br[W];

endmodule

// File: rtl/pipelined_subtractor_16bit.sv
// Three-stage a - b - bIn subtractor, 3-edge latency, 1/cycle; per-stage enables collapse
// bubbles and stall upstream only when every stage is full. SUB_OVERFLOW_EN adds signed ovf.
module pipelined_subtractor_16bit
   import pipe_arith_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input logic                         clk,
   input logic                         rst_n,
   pipelined_subtractor_16bit_if.slave sub
);

   localparam int HALF_W = halfWidth(DATA_W);

   logic              v1, v2, v3;
   logic              en1, en2, en3;
   stageCtl_t         ctl;

   logic [DATA_W-1:0] a1, b1;
   logic              bIn1;

   logic [HALF_W-1:0] dLo2, aHi2, bHi2;
   logic              br2;

   logic [DATA_W-1:0] diff3;
   logic              bOut3;

   logic [HALF_W-1:0] dLoNext, dHiNext;
   logic              brLoNext, brHiNext;

   // Enables chain from the output back so in_ready never looks at in_valid.
   assign en3 = !v3 | sub.out_ready;
   assign en2 = !v2 | en3;
   assign en1 = !v1 | en2;
   assign ctl = '{v1: v1, v2: v2, v3: v3, en1: en1, en2: en2, en3: en3};

   ripple_borrow_sub #(.W(HALF_W)) uLo (
      .x    (a1[HALF_W-1:0]),
      .y    (b1[HALF_W-1:0]),
      .bIn  (bIn1),
      .d    (dLoNext),
      .bOut (brLoNext)
   );

   ripple_borrow_sub #(.W(HALF_W)) uHi (
      .x    (aHi2),
      .y    (bHi2),
      .bIn  (br2),
      .d    (dHiNext),
      .bOut (brHiNext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         bIn1 <= 1'b0;
      end else if (ctl.en1) begin
         v1 <= sub.in_valid;
         if (sub.in_valid) begin
            a1   <= sub.a;
            b1   <= sub.b;
            bIn1 <= sub.bIn;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         dLo2 <= '0;
         aHi2 <= '0;
         bHi2 <= '0;
         br2  <= 1'b0;
      end else if (ctl.en2) begin
         v2 <= ctl.v1;
         if (ctl.v1) begin
            dLo2 <= dLoNext;
            aHi2 <= a1[DATA_W-1:HALF_W];
            bHi2 <= b1[DATA_W-1:HALF_W];
            br2  <= brLoNext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3    <= 1'b0;
         diff3 <= '0;
         bOut3 <= 1'b0;
      end else if (ctl.en3) begin
         v3 <= ctl.v2;
         if (ctl.v2) begin
            diff3 <= {dHiNext, dLo2};
            bOut3 <= brHiNext;
         end
      end
   end

`ifdef SUB_OVERFLOW_EN
   logic ovf3;

   // Signed overflow: operand signs differ and the result sign differs from the minuend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf3 <= 1'b0;
      end else if (ctl.en3 && ctl.v2) begin
         ovf3 <= (aHi2[HALF_W-1] ^ bHi2[HALF_W-1]) & (dHiNext[HALF_W-1] ^ aHi2[HALF_W-1]);
      end
   end

   assign sub.ovf = ovf3;
`endif

   assign sub.in_ready  = ctl.en1;
   assign sub.out_valid = ctl.v3;
   assign sub.diff      = diff3;
   assign sub.bOut      = bOut3;
   assign sub.busy      = ctl.v1 | ctl.v2 | ctl.v3;

endmodule

// File: tb/tb_pipelined_subtractor_16bit.sv
// Scoreboarded bench for pipelined_subtractor_16bit: expected results queued on
// acceptance, compared in order on each output handshake.
module tb_pipelined_subtractor_16bit;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipelined_subtractor_16bit_if #(.DATA_W(16)) bus ();

   pipelined_subtractor_16bit #(.DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sub   (bus)
   );

   typedef struct {
      logic [15:0] d;
      logic        b;
      logic        o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;
   int   pushes = 0;

   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      exp_t        e;
      logic [16:0] r;
      int          sa, sbv, s;
      r   = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
      sa  = {{16{av[15]}}, av};
      sbv = {{16{bv[15]}}, bv};
      s   = sa - sbv - (bi ? 1 : 0);
      e.d = r[15:0];
      e.b = r[16];
      e.o = (s > 32767) || (s < -32768);
      return e;
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
               pops++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result: got diff=%h bOut=%b, required no output", bus.diff, bus.bOut);
               end else begin
                  e = sb.pop_front();
                  if (bus.diff !== e.d || bus.bOut !== e.b) begin
                     errors++;
                     $display("FAIL result: got diff=%h bOut=%b, required diff=%h bOut=%b",
                              bus.diff, bus.bOut, e.d, e.b);
                  end
`ifdef SUB_OVERFLOW_EN
                  checks++;
                  if (bus.ovf !== e.o) begin
                     errors++;
                     $display("FAIL ovf: got %b, required %b (diff=%h)", bus.ovf, e.o, e.d);
                  end
`endif
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               sb.push_back(model(bus.a, bus.b, bus.bIn));
               pushes++;
            end
         end
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || bus.busy) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL drain: pending=%0d busy=%b after %0d cycles, required empty", sb.size(), bus.busy, n);
      end
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      int n = 0;
      bus.a        = av;
      bus.b        = bv;
      bus.bIn      = bi;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bIn       = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.diff !== 16'h0000 || bus.bOut !== 1'b0 ||
          bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b diff=%h bOut=%b busy=%b in_ready=%b, required 0 0000 0 0 1",
                  bus.out_valid, bus.diff, bus.bOut, bus.busy, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      int n;
      bus.out_ready = 1'b1;
      bus.a         = 16'h1234;
      bus.b         = 16'h0234;
      bus.bIn       = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL latency: out_valid after %0d edges, required 3", n);
      end
      checks++;
      if (bus.diff !== 16'h1000 || bus.bOut !== 1'b0) begin
         errors++;
         $display("FAIL latency_value: diff=%h bOut=%b, required 1000 0", bus.diff, bus.bOut);
      end
      wait_drain();
   endtask

   task automatic test_borrow();
      int p0 = pops;
      bus.out_ready = 1'b1;
      send(16'h0000, 16'h0001, 1'b0);
      send(16'h0100, 16'h0000, 1'b1);
      send(16'h00FF, 16'h00FF, 1'b1);
      wait_drain();
      checks++;
      if (pops - p0 !== 3) begin
         errors++;
         $display("FAIL borrow_count: %0d results, required 3", pops - p0);
      end
   endtask

   task automatic test_stall();
      int          acc = 0;
      int          p0  = pops;
      logic        fire;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.a   = 16'h1000 + 16'(acc * 'h111);
         bus.b   = 16'(acc * 'h101);
         bus.bIn = acc[0];
         @(negedge clk);
         if (!bus.in_ready) break;
         @(posedge clk); #1;
         acc++;
      end
      checks++;
      if (acc !== 3 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_fill: accepted %0d in_ready=%b, required 3 0", acc, bus.in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.diff !== 16'h1000 || bus.bOut !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: out_valid=%b diff=%h bOut=%b in_ready=%b, required 1 1000 0 0",
                     bus.out_valid, bus.diff, bus.bOut, bus.in_ready);
         end
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 20 && acc < 5; k++) begin
         bus.a   = 16'h1000 + 16'(acc * 'h111);
         bus.b   = 16'(acc * 'h101);
         bus.bIn = acc[0];
         @(negedge clk);
         fire = bus.in_ready;
         @(posedge clk); #1;
         if (fire) acc++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (acc !== 5) begin
         errors++;
         $display("FAIL stall_accept: accepted %0d, required 5", acc);
      end
      wait_drain();
      checks++;
      if (pops - p0 !== 5) begin
         errors++;
         $display("FAIL stall_count: %0d results, required 5", pops - p0);
      end
   endtask

   task automatic test_bubble();
      int n = 0;
      int p0, q0;
      bus.out_ready = 1'b0;
      send(16'h00F0, 16'h000F, 1'b0);
      while (!bus.out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL collapse: out_valid=%b in_ready=%b busy=%b, required 1 1 1",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
      bus.out_ready = 1'b1;
      wait_drain();
      p0 = pops;
      q0 = pushes;
      for (int k = 0; k < 24; k++) begin
         bus.in_valid  = (k % 2 == 0);
         bus.a         = 16'($urandom);
         bus.b         = 16'($urandom);
         bus.bIn       = 1'($urandom_range(0, 1));
         bus.out_ready = (k % 3 != 1);
         @(negedge clk);
         checks++;
         if (bus.out_ready && !bus.in_ready) begin
            errors++;
            $display("FAIL bubble_ready: in_ready=%b with out_ready=1, required 1", bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain();
      checks++;
      if (pops - p0 !== pushes - q0 || pushes - q0 < 6) begin
         errors++;
         $display("FAIL bubble_count: %0d results for %0d accepted, required equal and >= 6",
                  pops - p0, pushes - q0);
      end
   endtask

   task automatic test_back_to_back();
      int p0 = pops;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.a   = 16'($urandom);
         bus.b   = 16'($urandom);
         bus.bIn = 1'($urandom_range(0, 1));
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: cycle %0d in_ready=%b, required 1", k, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_drain();
      checks++;
      if (pops - p0 !== 20) begin
         errors++;
         $display("FAIL b2b_count: %0d results, required 20", pops - p0);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      int n = 0;
      bus.out_ready = 1'b0;
      send(16'hAAAA, 16'h1111, 1'b0);
      send(16'hBBBB, 16'h2222, 1'b1);
      send(16'hCCCC, 16'h3333, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.diff !== 16'h0000 || bus.bOut !== 1'b0 ||
          bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: out_valid=%b diff=%h bOut=%b busy=%b in_ready=%b, required 0 0000 0 0 1",
                  bus.out_valid, bus.diff, bus.bOut, bus.busy, bus.in_ready);
      end
      sb.delete();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      p0 = pops;
      send(16'h0005, 16'h0003, 1'b0);
      while (!bus.out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 16'h0002 || bus.bOut !== 1'b0) begin
         errors++;
         $display("FAIL reset_first: out_valid=%b diff=%h bOut=%b, required 1 0002 0",
                  bus.out_valid, bus.diff, bus.bOut);
      end
      wait_drain();
      checks++;
      if (pops - p0 !== 1) begin
         errors++;
         $display("FAIL reset_count: %0d results after release, required 1", pops - p0);
      end
   endtask

`ifdef SUB_OVERFLOW_EN
   task automatic test_ovf();
      int p0 = pops;
      bus.out_ready = 1'b1;
      send(16'h8000, 16'h0001, 1'b0);
      send(16'h0005, 16'h0003, 1'b0);
      send(16'h7FFF, 16'hFFFF, 1'b0);
      wait_drain();
      checks++;
      if (pops - p0 !== 3) begin
         errors++;
         $display("FAIL ovf_count: %0d results, required 3", pops - p0);
      end
   endtask
`endif

   initial begin
      fork
         monitor();
         begin
            #500000;
            $display("FAIL watchdog: simulation exceeded time limit");
            $fatal(1, "watchdog expired");
         end
      join_none
      test_reset();
      test_latency();
      test_borrow();
      test_stall();
      test_bubble();
      test_back_to_back();
      test_reset_mid();
`ifdef SUB_OVERFLOW_EN
      test_ovf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
